// File: rtl/image_pkg.sv
// image_pkg: shared state, beat-kind and point-op encodings for the BMP image pipeline
package image_pkg;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PIX  = 3'd2,
    ST_PAD  = 3'd3,
    ST_DONE = 3'd4
  } state_t;
  localparam logic [1:0] SEL_HDR = 2'b00;
  localparam logic [1:0] SEL_PIX = 2'b01;
  localparam logic [1:0] SEL_PAD = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_GRAY = 2'b01;
  localparam logic [1:0] OP_INV  = 2'b10;
  localparam int BMP_HDR_BYTES = 54;
  // BMP rows of 3-byte pixels are padded up to a multiple of 4 bytes
  function automatic int pad_bytes(input int w);
    return (4 - (3 * w) % 4) % 4;
  endfunction
endpackage

// File: rtl/raster_counter.sv
// raster_counter: column/row position of the pixel beat currently offered, advancing per accepted beat
module raster_counter #(
  parameter int WIDTH  = 512,
  parameter int HEIGHT = 768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        adv,
  output logic [15:0] col,
  output logic [15:0] row,
  output logic        eol,
  output logic        eof
);
  logic [15:0] col_q, row_q;
  assign col = col_q;
  assign row = row_q;
  assign eol = col_q == 16'(WIDTH - 1);
  assign eof = eol && row_q == 16'(HEIGHT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (clr) begin
      col_q <= '0;
      row_q <= '0;
    end else if (adv) begin
      col_q <= eol ? '0 : col_q + 16'd1;
      if (eol) row_q <= eof ? '0 : row_q + 16'd1;
    end
  end
endmodule

// File: rtl/image_frame_sequencer.sv
// image_frame_sequencer: sequences one BMP frame as header, pixel raster and row padding with source/sink handshakes
module image_frame_sequencer
  import image_pkg::*;
#(
  parameter int HEIGHT    = 768,
  parameter int WIDTH     = 512,
  parameter int HDR_BYTES = BMP_HDR_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic        abort,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic        snk_ready,
  output logic        snk_we,
  output logic [1:0]  snk_sel,
  output logic [5:0]  hdr_idx,
  output logic [15:0] col,
  output logic [15:0] row,
  output logic [1:0]  op_sel,
  output logic        busy,
  output logic        done,
  output logic        aborted
);
  localparam int PAD_BYTES = pad_bytes(WIDTH);
  state_t state_q, state_d;
  logic [5:0] hdr_q, hdr_d;
  logic [1:0] pad_q, pad_d, op_q, op_d;
  logic last_q, last_d, aborted_q, aborted_d;
  logic clr, adv, eol, eof;

  raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_raster (
    .clk(clk), .rst(rst), .clr(clr), .adv(adv),
    .col(col), .row(row), .eol(eol), .eof(eof)
  );

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    pad_d     = pad_q;
    op_d      = op_q;
    last_d    = last_q;
    aborted_d = 1'b0;
    src_ready = 1'b0;
    snk_we    = 1'b0;
    snk_sel   = SEL_HDR;
    clr       = 1'b0;
    adv       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_HDR;
          op_d    = (mode == 2'b11) ? OP_PASS : mode;
        end
      end
      ST_HDR: begin
        snk_we = snk_ready;
        if (snk_we) begin
          hdr_d   = (hdr_q == 6'(HDR_BYTES - 1)) ? 6'd0 : hdr_q + 6'd1;
          state_d = (hdr_q == 6'(HDR_BYTES - 1)) ? ST_PIX : ST_HDR;
        end
      end
      ST_PIX: begin
        snk_sel   = SEL_PIX;
        src_ready = snk_ready;
        snk_we    = src_valid && snk_ready;
        adv       = snk_we;
        // remember the final row so the trailing pad knows to finish the frame
        if (snk_we && eol) begin
          last_d  = eof;
          state_d = (PAD_BYTES != 0) ? ST_PAD : (eof ? ST_DONE : ST_PIX);
        end
      end
      ST_PAD: begin
        snk_sel = SEL_PAD;
        snk_we  = snk_ready;
        if (snk_we) begin
          pad_d   = (pad_q == 2'(PAD_BYTES - 1)) ? 2'd0 : pad_q + 2'd1;
          state_d = (pad_q != 2'(PAD_BYTES - 1)) ? ST_PAD : (last_q ? ST_DONE : ST_PIX);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        last_d  = 1'b0;
        clr     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // the beat offered this cycle still goes out; abort only ends the frame after it
    if (abort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      hdr_d     = 6'd0;
      pad_d     = 2'd0;
      last_d    = 1'b0;
      clr       = 1'b1;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hdr_q     <= '0;
      pad_q     <= '0;
      op_q      <= OP_PASS;
      last_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      pad_q     <= pad_d;
      op_q      <= op_d;
      last_q    <= last_d;
      aborted_q <= aborted_d;
    end
  end

  assign hdr_idx = hdr_q;
  assign op_sel  = op_q;
  assign busy    = state_q != ST_IDLE;
  assign done    = state_q == ST_DONE;
  assign aborted = aborted_q;
endmodule

// File: tb/tb_image_frame_sequencer.sv
// tb_image_frame_sequencer: directed checks on three geometries (4x2, 5x2, 1x1) sharing one stimulus set
module tb_image_frame_sequencer;
  import image_pkg::*;
  logic clk = 1'b0;
  logic rst, start, abort, src_valid, snk_ready;
  logic [1:0] mode;
  logic srdy[3], we[3], busy[3], done[3], abt[3];
  logic [1:0] ssel[3], op[3];
  logic [5:0] hidx[3];
  logic [15:0] col[3], row[3];
  int si;
  int pass_n = 0;
  int tot_n = 0;

  always #5 clk = ~clk;

  image_frame_sequencer #(.HEIGHT(2), .WIDTH(4)) d4 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .src_valid(src_valid), .src_ready(srdy[0]), .snk_ready(snk_ready), .snk_we(we[0]),
    .snk_sel(ssel[0]), .hdr_idx(hidx[0]), .col(col[0]), .row(row[0]), .op_sel(op[0]),
    .busy(busy[0]), .done(done[0]), .aborted(abt[0]));
  image_frame_sequencer #(.HEIGHT(2), .WIDTH(5)) d5 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .src_valid(src_valid), .src_ready(srdy[1]), .snk_ready(snk_ready), .snk_we(we[1]),
    .snk_sel(ssel[1]), .hdr_idx(hidx[1]), .col(col[1]), .row(row[1]), .op_sel(op[1]),
    .busy(busy[1]), .done(done[1]), .aborted(abt[1]));
  image_frame_sequencer #(.HEIGHT(1), .WIDTH(1)) d1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .src_valid(src_valid), .src_ready(srdy[2]), .snk_ready(snk_ready), .snk_we(we[2]),
    .snk_sel(ssel[2]), .hdr_idx(hidx[2]), .col(col[2]), .row(row[2]), .op_sel(op[2]),
    .busy(busy[2]), .done(done[2]), .aborted(abt[2]));

  task automatic do_rst;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b0; snk_ready = 1'b0; mode = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input int pad, input logic [1:0] md,
                           input logic [1:0] exp_op, input bit stall, input string nm);
    int k, pops, dones, dcyc, viol, bad, o, r, total;
    logic [1:0] es;
    bit fin;
    k = 0; pops = 0; dones = 0; dcyc = -1; viol = 0; bad = 0; fin = 1'b0;
    total = BMP_HDR_BYTES + (w + pad) * h;
    @(posedge clk); #1;
    start = 1'b1; mode = md; abort = 1'b0; src_valid = 1'b1; snk_ready = 1'b1;
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start = 1'b0;
        src_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        snk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      if (busy[si] && op[si] !== exp_op) viol++;
      if (srdy[si] && ssel[si] !== SEL_PIX) viol++;
      if (we[si] && !snk_ready) viol++;
      if (ssel[si] == SEL_PIX && busy[si] && we[si] !== (src_valid && snk_ready)) viol++;
      if (srdy[si] && src_valid) pops++;
      if (we[si]) begin
        o = (k - BMP_HDR_BYTES) % (w + pad);
        r = (k - BMP_HDR_BYTES) / (w + pad);
        es = (k < BMP_HDR_BYTES) ? SEL_HDR : (o < w ? SEL_PIX : SEL_PAD);
        if (ssel[si] !== es || (es == SEL_HDR && hidx[si] !== 6'(k)) ||
            (es == SEL_PIX && (col[si] !== 16'(o) || row[si] !== 16'(r)))) begin
          if (bad == 0)
            $display("first bad beat %0d: sel=%0d idx=%0d col=%0d row=%0d, want sel=%0d idx/col/row=%0d/%0d/%0d",
                     k, ssel[si], hidx[si], col[si], row[si], es, k, o, r);
          bad++;
        end
        k++;
      end
      if (done[si]) begin dones++; dcyc = c; fin = 1'b1; end
    end
    tot_n++; if (fin !== 1'b1) $display("FAIL %s timeout: done never seen", nm); else pass_n++;
    tot_n++; if (bad !== 0) $display("FAIL %s beat sequence: %0d bad beats, want 0", nm, bad); else pass_n++;
    tot_n++; if (k !== total) $display("FAIL %s beat count: got %0d want %0d", nm, k, total); else pass_n++;
    tot_n++; if (pops !== w * h) $display("FAIL %s src pops: got %0d want %0d", nm, pops, w * h); else pass_n++;
    tot_n++; if (dones !== 1) $display("FAIL %s done pulses: got %0d want 1", nm, dones); else pass_n++;
    tot_n++; if (viol !== 0) $display("FAIL %s handshake/op_sel: %0d violations, want 0", nm, viol); else pass_n++;
    if (!stall) begin
      tot_n++;
      if (dcyc !== total + 1) $display("FAIL %s done cycle: got %0d want %0d", nm, dcyc, total + 1);
      else pass_n++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    tot_n++;
    if (busy[si] !== 1'b0 || done[si] !== 1'b0 || col[si] !== 16'd0 || row[si] !== 16'd0)
      $display("FAIL %s after done: busy=%b done=%b col=%0d row=%0d want 0 0 0 0", nm, busy[si], done[si], col[si], row[si]);
    else pass_n++;
  endtask

  task automatic test_reset;
    si = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b1; snk_ready = 1'b1; mode = 2'b00;
    @(negedge clk);
    tot_n++; if (busy[0] !== 1'b0) $display("FAIL reset busy: got %b want 0", busy[0]); else pass_n++;
    tot_n++; if ({done[0], abt[0]} !== 2'b00) $display("FAIL reset done/aborted: got %b%b want 00", done[0], abt[0]); else pass_n++;
    tot_n++; if ({srdy[0], we[0]} !== 2'b00) $display("FAIL reset src_ready/snk_we: got %b%b want 00", srdy[0], we[0]); else pass_n++;
    tot_n++;
    if ({ssel[0], hidx[0], col[0], row[0]} !== 40'd0)
      $display("FAIL reset sel/idx/col/row: got %0d/%0d/%0d/%0d want 0", ssel[0], hidx[0], col[0], row[0]);
    else pass_n++;
    tot_n++; if (op[0] !== 2'b00) $display("FAIL reset op_sel: got %0d want 0", op[0]); else pass_n++;
    do_rst;
  endtask

  task automatic test_abort;
    bit hit;
    hit = 1'b0; si = 0;
    do_rst;
    @(posedge clk); #1;
    start = 1'b1; mode = 2'b01; src_valid = 1'b1; snk_ready = 1'b1;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done[0]) break;
      if (busy[0] && ssel[0] == SEL_PIX && row[0] == 16'd1 && col[0] == 16'd2) begin
        abort = 1'b1; hit = 1'b1;
      end
    end
    tot_n++; if (hit !== 1'b1) $display("FAIL abort reach row1 col2: got %b want 1", hit); else pass_n++;
    @(negedge clk);
    tot_n++; if (we[0] !== 1'b1) $display("FAIL abort in-cycle beat: snk_we=%b want 1", we[0]); else pass_n++;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    tot_n++; if (busy[0] !== 1'b0) $display("FAIL abort busy: got %b want 0", busy[0]); else pass_n++;
    tot_n++; if ({abt[0], done[0]} !== 2'b10) $display("FAIL abort pulse: aborted=%b done=%b want 1 0", abt[0], done[0]); else pass_n++;
    tot_n++; if ({col[0], row[0]} !== 32'd0) $display("FAIL abort counters: col=%0d row=%0d want 0 0", col[0], row[0]); else pass_n++;
    @(posedge clk); #1;
    @(negedge clk);
    tot_n++; if ({abt[0], done[0]} !== 2'b00) $display("FAIL abort one-shot: aborted=%b done=%b want 0 0", abt[0], done[0]); else pass_n++;
    run_frame(4, 2, 0, 2'b01, 2'b01, 1'b0, "restart");
  endtask

  task automatic test_idle_abort;
    si = 0;
    do_rst;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; mode = 2'b10;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    tot_n++;
    if ({busy[0], abt[0], op[0]} !== 4'b0000)
      $display("FAIL start+abort idle: busy=%b aborted=%b op=%0d want 0 0 0", busy[0], abt[0], op[0]);
    else pass_n++;
  endtask

  task automatic test_start_busy_rst;
    si = 0;
    do_rst;
    @(posedge clk); #1;
    start = 1'b1; mode = 2'b01; src_valid = 1'b1; snk_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin @(posedge clk); #1; start = 1'b0; end
    start = 1'b1; mode = 2'b10;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    tot_n++; if (op[0] !== 2'b01) $display("FAIL start while busy op_sel: got %0d want 1", op[0]); else pass_n++;
    tot_n++; if (busy[0] !== 1'b1) $display("FAIL start while busy busy: got %b want 1", busy[0]); else pass_n++;
    for (int c = 0; c < 30; c++) begin @(posedge clk); #1; end
    tot_n++; if (ssel[0] !== SEL_PIX || srdy[0] !== 1'b1) $display("FAIL mid-PIX setup: sel=%0d src_ready=%b want 1 1", ssel[0], srdy[0]); else pass_n++;
    #2 rst = 1'b1;
    #1;
    tot_n++;
    if ({srdy[0], we[0], busy[0], done[0], abt[0], ssel[0], hidx[0], col[0], row[0], op[0]} !== 47'd0)
      $display("FAIL async rst: ready=%b we=%b busy=%b sel=%0d idx=%0d col=%0d row=%0d op=%0d want all 0",
               srdy[0], we[0], busy[0], ssel[0], hidx[0], col[0], row[0], op[0]);
    else pass_n++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    si = 0; run_frame(4, 2, 0, 2'b01, 2'b01, 1'b0, "w4h2");
    do_rst; si = 1; run_frame(5, 2, 1, 2'b10, 2'b10, 1'b0, "w5h2");
    do_rst; si = 1; run_frame(5, 2, 1, 2'b01, 2'b01, 1'b1, "w5h2 stall");
    do_rst; si = 0; run_frame(4, 2, 0, 2'b10, 2'b10, 1'b1, "w4h2 stall");
    test_abort;
    test_idle_abort;
    test_start_busy_rst;
    do_rst; si = 0; run_frame(4, 2, 0, 2'b11, 2'b00, 1'b0, "mode11");
    do_rst; si = 2; run_frame(1, 1, 1, 2'b01, 2'b01, 1'b0, "w1h1");
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
